// File: rtl/arya_pkg.sv
// Shared constants for the arya core and its host-side memory controller:
// state encoding, sequencing constants and default widths.
package arya_pkg;

  localparam int DATAPATH_WIDTH_DEF = 64;
  localparam int MEM_ADDR_WIDTH_DEF = 10;
  localparam int RUN_CNT_WIDTH_DEF  = 16;
  localparam int CYCLE_CNT_WIDTH    = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_CLEAR  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    CLEAR  = ST_CLEAR,
    RUN    = ST_RUN,
    VERIFY = ST_VERIFY
  } state_t;

  // Core reset pulse length before each run, and host readback latency
  // (one BRAM cycle plus the output register).
  localparam int CLEAR_CYCLES = 2;
  localparam int READ_LATENCY = 2;

endpackage

// File: rtl/arya_run_timer.sv
// Loadable run-length down-counter. A load value of zero selects free-run,
// in which case the terminal count never fires.
module arya_run_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         tc
);

  logic [W-1:0] count;
  logic         free_run;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      free_run <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      free_run <= (load_val == '0);
    end else if (dec_en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Fires during the last counted cycle so the run lasts exactly load_val cycles.
  assign tc = !free_run && (count == W'(1));

endmodule

// File: rtl/arya_mem_ctrl.sv
// Host sequencer and port-B arbiter for the arya core.
// Optional feature: define ARYA_MEM_CTRL_CYCLE_CNT_EN to add run_cycle_count.
module arya_mem_ctrl
  import arya_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int RUN_CNT_WIDTH  = RUN_CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      setup_mem,
  input  logic                      verify_mem,
  input  logic                      start,
  input  logic                      stop,
  input  logic [RUN_CNT_WIDTH-1:0]  run_cycles,
  input  logic [MEM_ADDR_WIDTH-1:0] host_addr_in,
  input  logic [DATAPATH_WIDTH-1:0] host_data_in,
  input  logic                      host_wr_en,
  input  logic                      host_rd_en,
  output logic [DATAPATH_WIDTH-1:0] host_data_out,
  output logic                      host_rd_valid,
  output logic                      host_err,
  output logic                      busy,
  output logic                      done,
  output logic                      core_en,
  output logic                      core_rst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] core_addrb_in,
  input  logic [DATAPATH_WIDTH-1:0] core_dinb_in,
  input  logic                      core_web_in,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addrb_out,
  output logic [DATAPATH_WIDTH-1:0] mem_dinb_out,
  output logic                      mem_web_out,
  input  logic [DATAPATH_WIDTH-1:0] mem_doutb_in,
  output logic [DATAPATH_WIDTH-1:0] core_doutb_out,
`ifdef ARYA_MEM_CTRL_CYCLE_CNT_EN
  output logic [CYCLE_CNT_WIDTH-1:0] run_cycle_count,
`endif
  output logic [2:0]                state_dbg
);

  localparam logic [1:0] CLEAR_LAST = 2'(CLEAR_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] clr_cnt;
  logic       start_acc, run_end, timer_tc;
  logic       wr_ok, rd_ok, bad_strobe;
  logic       rd_p1;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    run_end   = 1'b0;
    case (state)
      IDLE: begin
        if (setup_mem)       state_nx = SETUP;
        else if (verify_mem) state_nx = VERIFY;
        else if (start) begin
          state_nx  = CLEAR;
          start_acc = 1'b1;
        end
      end
      SETUP:   if (!setup_mem)  state_nx = IDLE;
      VERIFY:  if (!verify_mem) state_nx = IDLE;
      CLEAR:   if (clr_cnt == CLEAR_LAST) state_nx = RUN;
      RUN: begin
        if (timer_tc || stop) begin
          state_nx = IDLE;
          run_end  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Host strobes are only honoured inside their windows; anything else is
  // dropped and flagged.
  always_comb begin
    wr_ok      = host_wr_en && (state == SETUP);
    rd_ok      = host_rd_en && ((state == SETUP) || (state == VERIFY));
    bad_strobe = (host_wr_en && !wr_ok) || (host_rd_en && !rd_ok);
  end

  always_comb begin
    mem_addrb_out = host_addr_in;
    mem_dinb_out  = host_data_in;
    mem_web_out   = wr_ok;
    if (state == RUN) begin
      mem_addrb_out = core_addrb_in;
      mem_dinb_out  = core_dinb_in;
      mem_web_out   = core_web_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_cnt       <= 2'd0;
      core_rst_n    <= 1'b0;
      done          <= 1'b0;
      host_err      <= 1'b0;
      rd_p1         <= 1'b0;
      host_rd_valid <= 1'b0;
      host_data_out <= '0;
    end else begin
      clr_cnt <= (state == CLEAR) ? clr_cnt + 2'd1 : 2'd0;
      // Core reset is only touched around a run; in IDLE the core keeps its state.
      if (state_nx == CLEAR)    core_rst_n <= 1'b0;
      else if (state_nx == RUN) core_rst_n <= 1'b1;
      done          <= run_end;
      host_err      <= (host_err && !start_acc) || bad_strobe;
      rd_p1         <= rd_ok;
      host_rd_valid <= rd_p1;
      if (rd_p1) host_data_out <= mem_doutb_in;
    end
  end

  arya_run_timer #(.W(RUN_CNT_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (start_acc),
    .load_val (run_cycles),
    .dec_en   (state == RUN),
    .tc       (timer_tc)
  );

`ifdef ARYA_MEM_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)                                   run_cycle_count <= '0;
    else if (start_acc)                           run_cycle_count <= '0;
    else if ((state == RUN) && (run_cycle_count != '1)) run_cycle_count <= run_cycle_count + 32'd1;
  end
`endif

  assign core_en        = (state == RUN);
  assign busy           = (state != IDLE);
  assign core_doutb_out = mem_doutb_in;
  assign state_dbg      = state;

endmodule

// File: tb/tb_arya_mem_ctrl.sv
// Self-checking bench for arya_mem_ctrl: window/strobe vector table with a
// readback scoreboard, plus run-sequencing scenarios.
module tb_arya_mem_ctrl;
  import arya_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int RW = 16;
  localparam logic [DW-1:0] PAT = 64'hA5A5_0000_0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          setup_mem = 1'b0, verify_mem = 1'b0, start = 1'b0, stop = 1'b0;
  logic [RW-1:0] run_cycles = '0;
  logic [AW-1:0] host_addr_in = '0;
  logic [DW-1:0] host_data_in = '0;
  logic          host_wr_en = 1'b0, host_rd_en = 1'b0;
  logic [DW-1:0] host_data_out;
  logic          host_rd_valid, host_err, busy, done, core_en, core_rst_n;
  logic [AW-1:0] core_addrb_in = '0;
  logic [DW-1:0] core_dinb_in = '0;
  logic          core_web_in = 1'b0;
  logic [AW-1:0] mem_addrb_out;
  logic [DW-1:0] mem_dinb_out;
  logic          mem_web_out;
  logic [DW-1:0] mem_doutb_in;
  logic [DW-1:0] core_doutb_out;
  logic [2:0]    state_dbg;
`ifdef ARYA_MEM_CTRL_CYCLE_CNT_EN
  logic [31:0]   run_cycle_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arya_mem_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .setup_mem      (setup_mem),
    .verify_mem     (verify_mem),
    .start          (start),
    .stop           (stop),
    .run_cycles     (run_cycles),
    .host_addr_in   (host_addr_in),
    .host_data_in   (host_data_in),
    .host_wr_en     (host_wr_en),
    .host_rd_en     (host_rd_en),
    .host_data_out  (host_data_out),
    .host_rd_valid  (host_rd_valid),
    .host_err       (host_err),
    .busy           (busy),
    .done           (done),
    .core_en        (core_en),
    .core_rst_n     (core_rst_n),
    .core_addrb_in  (core_addrb_in),
    .core_dinb_in   (core_dinb_in),
    .core_web_in    (core_web_in),
    .mem_addrb_out  (mem_addrb_out),
    .mem_dinb_out   (mem_dinb_out),
    .mem_web_out    (mem_web_out),
    .mem_doutb_in   (mem_doutb_in),
    .core_doutb_out (core_doutb_out),
`ifdef ARYA_MEM_CTRL_CYCLE_CNT_EN
    .run_cycle_count(run_cycle_count),
`endif
    .state_dbg      (state_dbg)
  );

  // Port-B BRAM model, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_web_out) mem[mem_addrb_out] <= mem_dinb_out;
    mem_doutb_in <= mem[mem_addrb_out];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && host_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_unexpected: got valid with data 0x%0h, want no read", host_data_out);
      end else begin
        chk("rd_data", host_data_out, exp_q.pop_front());
        chk("rd_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          setup, verify, st, wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_web, exp_rd;
    logic [DW-1:0] exp_rdata;
    logic [2:0]    exp_state;
    logic          exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, v, st, wr, rd, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic ew, erd,
                              input logic [DW-1:0] erdata, input logic [2:0] est,
                              input logic eerr);
    vec_t r;
    r.setup = s; r.verify = v; r.st = st; r.wr = wr; r.rd = rd;
    r.addr = a; r.wdata = wd; r.exp_web = ew; r.exp_rd = erd;
    r.exp_rdata = erdata; r.exp_state = est; r.exp_err = eerr;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_row(input int idx, input vec_t v);
    setup_mem = v.setup; verify_mem = v.verify; start = v.st;
    host_wr_en = v.wr; host_rd_en = v.rd;
    host_addr_in = v.addr; host_data_in = v.wdata;
    if (v.exp_rd) begin
      exp_q.push_back(v.exp_rdata);
      exp_cyc_q.push_back(cyc + READ_LATENCY);
    end
    @(negedge clk);
    chk($sformatf("row%0d_web", idx), 64'(mem_web_out), 64'(v.exp_web));
    if (v.exp_web) chk($sformatf("row%0d_waddr", idx), 64'(mem_addrb_out), 64'(v.addr));
    @(posedge clk); #1;
    chk($sformatf("row%0d_state", idx), 64'(state_dbg), 64'(v.exp_state));
    chk($sformatf("row%0d_err", idx), 64'(host_err), 64'(v.exp_err));
  endtask

  task automatic idle_inputs();
    setup_mem = 0; verify_mem = 0; start = 0; stop = 0;
    host_wr_en = 0; host_rd_en = 0; host_addr_in = '0; host_data_in = '0;
    core_addrb_in = '0; core_dinb_in = '0; core_web_in = 0; reset = 1;
  endtask

  logic          ce_s[0:63], crn_s[0:63], dn_s[0:63], busy_s[0:63], err_s[0:63], web_s[0:63];
  logic [AW-1:0] addr_s[0:63];

  // start pulse at cycle 0; samples for cycles 1..n. poke_at drives a stray
  // start and a host write during the run; rst_at pulls reset for one cycle.
  task automatic run_seq(input logic [RW-1:0] cycles, input int n, input int stop_at,
                         input int rst_at, input int poke_at);
    run_cycles = cycles; start = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= n; i++) begin
      start = (i == poke_at);
      run_cycles = (i == poke_at) ? RW'(3) : cycles;
      stop = (i == stop_at);
      reset = (i == rst_at) ? 1'b0 : 1'b1;
      host_wr_en = (i == poke_at);
      host_addr_in = 10'h003; host_data_in = '1;
      core_addrb_in = 10'h2AA; core_dinb_in = 64'h1234; core_web_in = 0;
      @(negedge clk);
      ce_s[i] = core_en; crn_s[i] = core_rst_n; dn_s[i] = done;
      busy_s[i] = busy; err_s[i] = host_err; web_s[i] = mem_web_out; addr_s[i] = mem_addrb_out;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  function automatic int cnt(input logic s[0:63], input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (s[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first(input logic s[0:63], input int n);
    for (int i = 1; i <= n; i++) if (s[i] === 1'b1) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vq.push_back(mk(0,0,0,0,0, 10'd0, '0,        0,0, '0,      ST_IDLE,   0));
    vq.push_back(mk(1,1,1,0,0, 10'd0, '0,        0,0, '0,      ST_SETUP,  0));
    vq.push_back(mk(1,0,0,1,0, 10'd0, PAT|64'd0, 1,0, '0,      ST_SETUP,  0));
    vq.push_back(mk(1,0,0,1,0, 10'd1, PAT|64'd1, 1,0, '0,      ST_SETUP,  0));
    vq.push_back(mk(1,0,0,1,0, 10'd2, PAT|64'd2, 1,0, '0,      ST_SETUP,  0));
    vq.push_back(mk(1,0,0,1,0, 10'd3, PAT|64'd3, 1,0, '0,      ST_SETUP,  0));
    vq.push_back(mk(1,0,0,0,1, 10'd0, '0,        0,1, PAT|64'd0, ST_SETUP, 0));
    vq.push_back(mk(0,0,0,0,0, 10'd0, '0,        0,0, '0,      ST_IDLE,   0));
    vq.push_back(mk(0,1,0,0,0, 10'd0, '0,        0,0, '0,      ST_VERIFY, 0));
    vq.push_back(mk(0,1,0,0,1, 10'd0, '0,        0,1, PAT|64'd0, ST_VERIFY, 0));
    vq.push_back(mk(0,1,0,0,1, 10'd1, '0,        0,1, PAT|64'd1, ST_VERIFY, 0));
    vq.push_back(mk(0,1,0,0,1, 10'd2, '0,        0,1, PAT|64'd2, ST_VERIFY, 0));
    vq.push_back(mk(0,1,0,0,1, 10'd3, '0,        0,1, PAT|64'd3, ST_VERIFY, 0));
    vq.push_back(mk(0,0,0,0,1, 10'd0, '0,        0,1, PAT|64'd0, ST_IDLE,   0));
    vq.push_back(mk(0,1,0,0,0, 10'd0, '0,        0,0, '0,      ST_VERIFY, 0));
    vq.push_back(mk(0,1,0,1,0, 10'd2, 64'hDEAD_BEEF_DEAD_BEEF, 0,0, '0, ST_VERIFY, 1));
    vq.push_back(mk(0,1,0,0,1, 10'd2, '0,        0,1, PAT|64'd2, ST_VERIFY, 1));
    vq.push_back(mk(0,0,0,0,0, 10'd0, '0,        0,0, '0,      ST_IDLE,   1));
    vq.push_back(mk(0,0,0,0,1, 10'd0, '0,        0,0, '0,      ST_IDLE,   1));
    vq.push_back(mk(1,0,0,0,0, 10'd0, '0,        0,0, '0,      ST_SETUP,  1));
    vq.push_back(mk(0,0,0,0,0, 10'd0, '0,        0,0, '0,      ST_IDLE,   1));

    // Reset state
    idle_inputs();
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    chk("rst_core_en", 64'(core_en), 0);
    chk("rst_core_rst_n", 64'(core_rst_n), 0);
    chk("rst_data_out", host_data_out, 0);
    chk("rst_rd_valid", 64'(host_rd_valid), 0);
    chk("rst_err", 64'(host_err), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_web", 64'(mem_web_out), 0);
    chk("rst_mem_addr", 64'(mem_addrb_out), 0);
    chk("rst_mem_din", mem_dinb_out, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("idle_core_rst_n", 64'(core_rst_n), 0);

    // Window / strobe table
    for (int i = 0; i < vq.size(); i++) drive_row(i, vq[i]);
    idle_inputs();
    repeat (3) @(posedge clk); #1;
    chk("rd_queue_drained", 64'(exp_q.size()), 0);
    chk("data_out_hold", host_data_out, PAT | 64'd2);

    // Bounded run of 10 with a stray start and host write during RUN
    run_seq(RW'(10), 16, 0, 0, 5);
    chk("b_err_cleared", 64'(err_s[1]), 0);
    chk("b_busy", 64'(busy_s[1]), 1);
    chk("b_rstn_c1", 64'(crn_s[1]), 0);
    chk("b_rstn_c2", 64'(crn_s[2]), 0);
    chk("b_rstn_run", 64'(crn_s[3]), 1);
    chk("b_rstn_low_cnt", 64'(16 - cnt(crn_s, 16)), 2);
    chk("b_first_ce", 64'(first(ce_s, 16)), 3);
    chk("b_ce_cnt", 64'(cnt(ce_s, 16)), 10);
    chk("b_done_cnt", 64'(cnt(dn_s, 16)), 1);
    chk("b_done_at", 64'(first(dn_s, 16)), 13);
    chk("b_run_web", 64'(web_s[5]), 0);
    chk("b_run_addr", 64'(addr_s[5]), 64'h2AA);
    chk("b_err_in_run", 64'(err_s[6]), 1);
    chk("b_idle_after", 64'(busy_s[14]), 0);
    chk("b_core_not_reset", 64'(crn_s[16]), 1);
    chk("b_data_out_hold", host_data_out, PAT | 64'd2);
`ifdef ARYA_MEM_CTRL_CYCLE_CNT_EN
    chk("b_cycle_count", 64'(run_cycle_count), 10);
`endif

    // Free run stopped on its 37th RUN cycle
    run_seq(RW'(0), 45, 39, 0, 0);
    chk("f_first_ce", 64'(first(ce_s, 45)), 3);
    chk("f_ce_cnt", 64'(cnt(ce_s, 45)), 37);
    chk("f_ce_drop", 64'(ce_s[40]), 0);
    chk("f_done_at", 64'(first(dn_s, 45)), 40);
    chk("f_done_cnt", 64'(cnt(dn_s, 45)), 1);

    // Stop coinciding with terminal count
    run_seq(RW'(4), 10, 6, 0, 0);
    chk("t_ce_cnt", 64'(cnt(ce_s, 10)), 4);
    chk("t_done_cnt", 64'(cnt(dn_s, 10)), 1);
    chk("t_done_at", 64'(first(dn_s, 10)), 7);

    // Reset on the 5th RUN cycle of a 20-cycle run
    run_seq(RW'(20), 30, 0, 7, 5);
    chk("r_err_set", 64'(err_s[6]), 1);
    chk("r_ce_before", 64'(ce_s[7]), 1);
    chk("r_ce_after", 64'(ce_s[8]), 0);
    chk("r_busy_after", 64'(busy_s[8]), 0);
    chk("r_rstn_after", 64'(crn_s[8]), 0);
    chk("r_err_after", 64'(err_s[8]), 0);
    chk("r_done_cnt", 64'(cnt(dn_s, 30)), 0);
    chk("r_ce_cnt", 64'(cnt(ce_s, 30)), 5);
    chk("r_rstn_held", 64'(crn_s[30]), 0);
    chk("r_data_out", host_data_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
